// File: rtl/risc_imem.sv
// risc_imem: instruction memory plus program loader for the RISC instruction
// unit. A host streams DATA_W-bit words in through a valid/ready load port;
// once loaded, every fetch request returns mem[pc] one cycle later.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load_start        begin a (re)load at address 0 (IDLE or RUN only)
//   i_load_valid        i_load_data is valid this cycle
//   i_load_last         marks the final word (only meaningful with valid)
//   i_load_data         instruction word to store
//   o_load_ready        high while in LOAD
//   o_load_done         one-cycle pulse the cycle after the load ends
//   o_load_count        number of words in the current program (0..DEPTH)
//   i_fetch_en, i_pc    fetch request and address (RUN only)
//   o_instruction       fetched word (holds between fetches)
//   o_instr_valid       o_instruction was updated by a fetch this cycle
//   o_fetch_err         one-cycle pulse: fetched address beyond program
//   o_busy              high while in LOAD
//   o_state             current FSM state (IDLE=0, LOAD=1, RUN=2)
//
// Load handshake: a word transfers on every rising edge where the block is in
// LOAD (o_load_ready=1) and i_load_valid=1. i_load_valid may be held low for
// any number of cycles; the load simply stalls.
module risc_imem #(
  parameter int DATA_W = 13,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic              i_load_last,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_load_count,
  input  logic              i_fetch_en,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_instr_valid,
  output logic              o_fetch_err,
  output logic              o_busy,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_load_count;
  logic              r_load_done;
  logic [DATA_W-1:0] r_instruction;
  logic              r_instr_valid;
  logic              r_fetch_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_accept;
  logic w_load_end;
  logic w_start;
  logic w_fetch;
  logic w_in_range;

  assign w_accept   = (r_state == S_LOAD) && i_load_valid;
  // The DEPTH-th word ends the load even without load_last; wptr then wraps.
  assign w_load_end = w_accept && (i_load_last || (r_wptr == ADDR_W'(DEPTH - 1)));
  assign w_start    = i_load_start && ((r_state == S_IDLE) || (r_state == S_RUN));
  // A reload request wins over a simultaneous fetch; that fetch is dropped.
  assign w_fetch    = (r_state == S_RUN) && i_fetch_en && !i_load_start;
  assign w_in_range = ({1'b0, i_pc} < r_load_count);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_load_start) w_next = S_LOAD;
      S_LOAD:  if (w_load_end)   w_next = S_RUN;
      S_RUN:   if (i_load_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Loader bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr       <= '0;
      r_load_count <= '0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= w_load_end;
      if (w_start) begin
        r_wptr       <= '0;
        r_load_count <= '0;
      end else if (w_accept) begin
        r_wptr       <= r_wptr + 1'b1;
        r_load_count <= r_load_count + 1'b1;
      end
    end
  end

  // Storage array: never cleared, written only by accepted load words.
  always_ff @(posedge i_clk) begin
    if (w_accept && !i_rst) begin
      r_mem[r_wptr] <= i_load_data;
    end
  end

  // Fetch path: one-cycle read latency, out-of-range reads return a NOP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      if (w_start) begin
        r_instruction <= '0;
      end else if (w_fetch) begin
        r_instr_valid <= 1'b1;
        if (w_in_range) begin
          r_instruction <= r_mem[i_pc];
        end else begin
          r_instruction <= '0;
          r_fetch_err   <= 1'b1;
        end
      end
    end
  end

  assign o_load_ready  = (r_state == S_LOAD);
  assign o_busy        = (r_state == S_LOAD);
  assign o_load_done   = r_load_done;
  assign o_load_count  = r_load_count;
  assign o_instruction = r_instruction;
  assign o_instr_valid = r_instr_valid;
  assign o_fetch_err   = r_fetch_err;
  assign o_state       = r_state;

endmodule

// File: doc/risc_imem.md
Name: risc_imem

Overview:
- Instruction memory and program loader that answers the RISC instruction unit's fetches.
- A host streams 13-bit instruction words in through a valid/ready load port. After the load, the block returns the word at the fetch unit's 5-bit pc one cycle after each fetch request.
- Sits between the testbench/host loader and the instruction unit. Its `instruction` output drives the instruction unit's `instruction` input, and its `pc` input is driven by the instruction unit's `pc` output.

Parameters:
- DATA_W, 13, instruction word width
- ADDR_W, 5, pc/address width
- DEPTH, 32, number of words (must equal 2**ADDR_W)

Ports:
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- load_start  input  1  begin (re)load of program at address 0
- load_valid  input  1  load_data is valid this cycle
- load_last  input  1  qualifies load_valid: this is the final word
- load_data  input  DATA_W  instruction word to store
- load_ready  output  1  block accepts a load word this cycle
- load_done  output  1  one-cycle pulse when load completes
- load_count  output  ADDR_W+1  number of words in the current program (0..DEPTH)
- fetch_en  input  1  fetch request for address pc
- pc  input  ADDR_W  fetch address
- instruction  output  DATA_W  fetched word
- instr_valid  output  1  instruction updated by a fetch this cycle
- fetch_err  output  1  one-cycle pulse: fetch of an address with no loaded word
- busy  output  1  high in LOAD state

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE; load_ready=0, load_done=0, load_count=0.
  - instruction=0, instr_valid=0, fetch_err=0, busy=0.
  - Write pointer is 0.
  - The memory array is not cleared.
- State IDLE:
  - fetch_en is ignored.
  - load_start → LOAD; write pointer=0; load_count=0.
- State LOAD:
  - busy=1. load_ready=1 combinationally in LOAD; it is 0 in all other states.
  - Handshake: when load_valid && load_ready, store mem[wptr]=load_data, then wptr+1 and load_count+1.
  - Load ends on the accepted word with load_last=1, or on the DEPTH-th accepted word (wptr wraps to 0 and is unused).
  - On end: next state RUN, and load_done=1 for exactly the following cycle. load_count then holds (DEPTH → 6'd32).
  - load_start is ignored in LOAD. fetch_en is ignored in LOAD: instr_valid=0 and instruction holds.
  - load_valid=0 stalls the load indefinitely; no timeout.
- State RUN:
  - With fetch_en=1 at edge N: at edge N+1, instruction=mem[pc], instr_valid=1 (1-cycle read latency).
  - Back-to-back fetches give one result per cycle.
  - fetch_en=0: instr_valid=0 next cycle; instruction holds its last value.
  - pc >= load_count: instruction=0 (NOP), instr_valid=1, fetch_err=1 for that cycle.
  - load_start → LOAD. This takes priority over a simultaneous fetch_en, and that fetch produces no result. On entry to LOAD, instruction=0 and instr_valid=0.
- Reset mid-load: returns to IDLE with load_count=0. Partial contents remain but are unreachable until a new load.
- load_last with load_valid=0 is ignored.
- load_count width ADDR_W+1 so a full memory is representable. pc compared unsigned, zero-extended.

Test Plan:
- Reset then load: rst=1 for 2 cycles → all outputs 0. Then load_start and 3 words 13'h0208, 13'h05f1, 13'h06aa (last on 3rd) → load_ready high during LOAD, load_done one pulse after the 3rd word, load_count=3.
- Fetch latency: in RUN, fetch_en=1 with pc=0,1,2 on consecutive cycles → instruction=13'h0208, 13'h05f1, 13'h06aa on the following cycles, instr_valid=1 each cycle, fetch_err=0.
- Out-of-range: pc=5, fetch_en=1 with load_count=3 → instruction=0, instr_valid=1, fetch_err=1 for one cycle. fetch_en low next cycle → instr_valid=0 and instruction holds 0.
- Full load and stall: 32 words, value = address + 13'h1000, with load_valid deasserted every other cycle and load_last never asserted → load ends after word 32, load_count=32. Fetch pc=31 → 13'h101f.
- Reload priority: in RUN, assert load_start and fetch_en together → no instr_valid, state LOAD, instruction=0. Load 1 word 13'h1b04 → fetch pc=0 returns 13'h1b04; fetch pc=1 gives fetch_err=1.
- Reset mid-load: rst after 2 of 4 words → IDLE, load_count=0, fetch_en ignored (instr_valid stays 0) until a new load completes.
